// File: rtl/tpu_act_writeback_if.sv
// tpu_act_writeback_if
// Bus bundle for the activation/write-back stage: the accumulator-row
// valid/ready handshake on the input side and the unified-buffer write
// port on the output side.
//   acc_valid_i   producer -> stage   row valid
//   acc_row_i     producer -> stage   N lanes, lane i = bits [i*AW +: AW]
//   acc_ready_o   stage -> producer   row accepted when valid && ready
//   ub_wr_en_o    stage -> UB         write strobe
//   ub_wr_addr_o  stage -> UB         write address
//   ub_wr_data_o  stage -> UB         write data (signed DW-bit)
// slave  = the write-back stage's view, master = the producer/UB side.
interface tpu_act_writeback_if #(
  parameter int N     = 4,
  parameter int AW    = 32,
  parameter int DW    = 8,
  parameter int UB_AW = 8
) ();
  logic              acc_valid_i;
  logic [N*AW-1:0]   acc_row_i;
  logic              acc_ready_o;
  logic              ub_wr_en_o;
  logic [UB_AW-1:0]  ub_wr_addr_o;
  logic [DW-1:0]     ub_wr_data_o;

  modport slave (
    input  acc_valid_i,
    input  acc_row_i,
    output acc_ready_o,
    output ub_wr_en_o,
    output ub_wr_addr_o,
    output ub_wr_data_o
  );

  modport master (
    output acc_valid_i,
    output acc_row_i,
    input  acc_ready_o,
    input  ub_wr_en_o,
    input  ub_wr_addr_o,
    input  ub_wr_data_o
  );
endinterface

// File: rtl/tpu_act_writeback.sv
// tpu_act_writeback
// Post-accumulator activation and write-back. Takes N-lane signed rows,
// applies optional ReLU, rounding arithmetic right shift and signed DW-bit
// saturation, and writes the N results one per cycle to consecutive
// unified-buffer addresses.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   start_i             launch pulse, sampled in IDLE only
//   relu_en_i, shift_i  activation config, latched at start
//   base_addr_i         first UB address, latched at start
//   row_count_i         rows in the job (0 = empty job)
//   bus_if (slave)      accumulator handshake + UB write port
//   busy_o              state != IDLE
//   done_o              one-cycle pulse at job end
//   sat_o               sticky saturation flag, cleared at accepted start
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for start_i
// WAIT_ROW | acc_ready_o high, waiting for an accumulator row
// DRAIN    | one lane per cycle -> registered UB write
// DONE     | job finished, done_o pulses on the next cycle
module tpu_act_writeback #(
  parameter int N     = 4,
  parameter int AW    = 32,
  parameter int DW    = 8,
  parameter int UB_AW = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             relu_en_i,
  input  logic [4:0]       shift_i,
  input  logic [UB_AW-1:0] base_addr_i,
  input  logic [7:0]       row_count_i,
  tpu_act_writeback_if.slave bus_if,
  output logic             busy_o,
  output logic             done_o,
  output logic             sat_o
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [AW:0] Q_MAX = (AW+1)'(2**(DW-1) - 1);
  localparam logic signed [AW:0] Q_MIN = (AW+1)'(-(2**(DW-1)));

  typedef enum logic [1:0] {IDLE, WAIT_ROW, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic             relu_q, relu_d;
  logic [4:0]       shift_q, shift_d;
  logic [UB_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]       rows_left_q, rows_left_d;
  logic [N*AW-1:0]  row_q, row_d;
  logic [LW-1:0]    lane_idx_q, lane_idx_d;
  logic             wr_en_q, wr_en_d;
  logic [UB_AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;

  // The row register shifts down one lane per DRAIN cycle, so the lane
  // being processed is always the bottom AW bits.
  logic signed [AW-1:0] lane_raw;
  logic signed [AW:0]   lane_x;
  logic signed [AW:0]   round_add;
  logic signed [AW:0]   lane_r;
  logic [DW-1:0]        lane_q;
  logic                 lane_sat;

  assign lane_raw = row_q[AW-1:0];

  // One extra bit of headroom keeps x + 2^(shift-1) from overflowing.
  always_comb begin
    lane_x    = (relu_q && lane_raw[AW-1]) ? '0 : {lane_raw[AW-1], lane_raw};
    round_add = '0;
    if (shift_q != 5'd0) begin
      round_add[shift_q - 5'd1] = 1'b1;
    end
    lane_r   = (lane_x + round_add) >>> shift_q;
    lane_q   = lane_r[DW-1:0];
    lane_sat = 1'b0;
    if (lane_r > Q_MAX) begin
      lane_q   = Q_MAX[DW-1:0];
      lane_sat = 1'b1;
    end else if (lane_r < Q_MIN) begin
      lane_q   = Q_MIN[DW-1:0];
      lane_sat = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    relu_d      = relu_q;
    shift_d     = shift_q;
    wr_ptr_d    = wr_ptr_q;
    rows_left_d = rows_left_q;
    row_d       = row_q;
    lane_idx_d  = lane_idx_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    done_d      = 1'b0;
    sat_d       = sat_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          relu_d      = relu_en_i;
          shift_d     = shift_i;
          wr_ptr_d    = base_addr_i;
          rows_left_d = row_count_i;
          sat_d       = 1'b0;
          state_d     = (row_count_i == 8'd0) ? DONE : WAIT_ROW;
        end
      end
      WAIT_ROW: begin
        if (bus_if.acc_valid_i) begin
          row_d      = bus_if.acc_row_i;
          lane_idx_d = '0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        wr_en_d    = 1'b1;
        wr_addr_d  = wr_ptr_q;
        wr_data_d  = lane_q;
        sat_d      = sat_q | lane_sat;
        wr_ptr_d   = wr_ptr_q + UB_AW'(1);
        row_d      = row_q >> AW;
        lane_idx_d = lane_idx_q + LW'(1);
        if (lane_idx_q == LW'(N-1)) begin
          lane_idx_d  = '0;
          rows_left_d = rows_left_q - 8'd1;
          state_d     = (rows_left_q == 8'd1) ? DONE : WAIT_ROW;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rows_left_q <= '0;
      row_q       <= '0;
      lane_idx_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      relu_q      <= relu_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rows_left_q <= rows_left_d;
      row_q       <= row_d;
      lane_idx_q  <= lane_idx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
    end
  end

  assign bus_if.acc_ready_o  = (state_q == WAIT_ROW);
  assign bus_if.ub_wr_en_o   = wr_en_q;
  assign bus_if.ub_wr_addr_o = wr_addr_q;
  assign bus_if.ub_wr_data_o = wr_data_q;
  assign busy_o              = (state_q != IDLE);
  assign done_o              = done_q;
  assign sat_o               = sat_q;

endmodule

// File: tb/tb_tpu_act_writeback.sv
module tb_tpu_act_writeback;
  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 8;
  localparam int UB_AW = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             start_i = 1'b0;
  logic             relu_en_i = 1'b0;
  logic [4:0]       shift_i = '0;
  logic [UB_AW-1:0] base_addr_i = '0;
  logic [7:0]       row_count_i = '0;
  logic             busy_o;
  logic             done_o;
  logic             sat_o;

  tpu_act_writeback_if #(.N(N), .AW(AW), .DW(DW), .UB_AW(UB_AW)) bus ();

  tpu_act_writeback #(.N(N), .AW(AW), .DW(DW), .UB_AW(UB_AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (start_i),
    .relu_en_i   (relu_en_i),
    .shift_i     (shift_i),
    .base_addr_i (base_addr_i),
    .row_count_i (row_count_i),
    .bus_if      (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sat_o       (sat_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    bit sat;
    int cyc;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  lanes_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  // Write/done monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.ub_wr_en_o)
        wr_q.push_back('{int'(bus.ub_wr_addr_o), int'($signed(bus.ub_wr_data_o)), sat_o, cyc});
      if (done_o)
        done_q.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: ReLU, round-half-up division by 2^sh (floor), clamp to int8.
  function automatic int q_model(input bit relu, input int sh, input int lane, output bit sat);
    longint x, d, n, r;
    x = (relu && lane < 0) ? 64'sd0 : longint'(lane);
    if (sh == 0) begin
      r = x;
    end else begin
      d = longint'(1) << sh;
      n = x + d / 2;
      r = n / d;
      if ((n % d) != 0 && n < 0) r = r - 1;
    end
    sat = 1'b0;
    if (r > 127) begin
      sat = 1'b1; r = 127;
    end else if (r < -128) begin
      sat = 1'b1; r = -128;
    end
    return int'(r);
  endfunction

  function automatic int rand_lane();
    case ($urandom_range(0, 3))
      0:       return int'($urandom);
      1:       return int'($urandom_range(0, 800)) - 400;
      2:       return int'($urandom_range(0, 80000)) - 40000;
      default: return int'($urandom_range(0, 4000)) - 2000;
    endcase
  endfunction

  function automatic logic [N*AW-1:0] build_row(input int r);
    logic [N*AW-1:0] row;
    row = '0;
    for (int i = 0; i < N; i++) row[i*AW +: AW] = lanes_q[r*N + i];
    return row;
  endfunction

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic present_row(input logic [N*AW-1:0] row, output bit ok, output int hs_cyc);
    ok = 1'b0;
    hs_cyc = 0;
    bus.acc_valid_i = 1'b1;
    bus.acc_row_i   = row;
    for (int t = 0; t < 200; t++) begin
      if (bus.acc_ready_o) begin
        @(negedge clk);
        hs_cyc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.acc_valid_i = 1'b0;
    bus.acc_row_i   = '0;
    check_val("row handshake", longint'(ok), 1);
  endtask

  task automatic run_job(input string tag, input bit relu, input int sh, input int base,
                         input int cnt, input int gap, input bit poke);
    int  hs[$];
    int  start_cyc;
    bit  ok;
    int  h;
    bit  exp_sat;
    bit  s;
    int  exp_d;
    int  lim;
    bit  got_done;
    int  exp_done;
    wr_q.delete();
    done_q.delete();
    exp_sat  = 1'b0;
    got_done = 1'b0;

    start_i     = 1'b1;
    relu_en_i   = relu;
    shift_i     = 5'(sh);
    base_addr_i = 8'(base);
    row_count_i = 8'(cnt);
    @(negedge clk);
    start_i     = 1'b0;
    start_cyc   = cyc;
    relu_en_i   = ~relu;
    shift_i     = 5'($urandom);
    base_addr_i = 8'($urandom);
    row_count_i = 8'($urandom_range(1, 9));
    check_val({tag, " busy after start"}, longint'(busy_o), 1);
    check_val({tag, " ready after start"}, longint'(bus.acc_ready_o), longint'(cnt != 0));

    for (int r = 0; r < cnt; r++) begin
      repeat (gap) @(negedge clk);
      present_row(build_row(r), ok, h);
      if (!ok) break;
      hs.push_back(h);
      check_val({tag, " ready in drain"}, longint'(bus.acc_ready_o), 0);
      if (poke && r == 0) begin
        start_i     = 1'b1;
        relu_en_i   = ~relu;
        shift_i     = 5'(sh + 7);
        base_addr_i = 8'(base + 100);
        row_count_i = 8'd0;
        @(negedge clk);
        start_i = 1'b0;
      end
    end

    for (int t = 0; t < 300 && done_q.size() == 0; t++) begin
      @(negedge clk);
      #1;
    end
    got_done = (done_q.size() != 0);
    check_val({tag, " done seen"}, longint'(got_done), 1);
    @(negedge clk);
    #1;
    check_val({tag, " busy after done"}, longint'(busy_o), 0);
    check_val({tag, " done pulse count"}, done_q.size(), got_done ? 1 : 0);
    check_val({tag, " write count"}, wr_q.size(), cnt * N);

    lim = (wr_q.size() < cnt * N) ? wr_q.size() : cnt * N;
    for (int k = 0; k < lim; k++) begin
      exp_d = q_model(relu, sh, lanes_q[k], s);
      exp_sat = exp_sat | s;
      check_val({tag, " addr"}, wr_q[k].addr, (base + k) % 256);
      check_val({tag, " data"}, wr_q[k].data, exp_d);
      check_val({tag, " sat at write"}, longint'(wr_q[k].sat), longint'(exp_sat));
      if (k % N == 0) begin
        if (k / N < hs.size())
          check_val({tag, " row latency"}, wr_q[k].cyc, hs[k / N] + 1);
      end else begin
        check_val({tag, " gap-free lanes"}, wr_q[k].cyc, wr_q[k-1].cyc + 1);
      end
    end

    if (got_done) begin
      if (cnt == 0) exp_done = start_cyc + 1;
      else if (wr_q.size() > 0) exp_done = wr_q[wr_q.size()-1].cyc + 1;
      else exp_done = -1;
      check_val({tag, " done timing"}, done_q[0], exp_done);
    end
    check_val({tag, " sat final"}, longint'(sat_o), longint'(exp_sat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int h;
    int cnt;
    bus.acc_valid_i = 1'b0;
    bus.acc_row_i   = '0;

    #2 reset_n = 1'b0;
    #1;
    check_val("reset ub_wr_en", longint'(bus.ub_wr_en_o), 0);
    check_val("reset ub_wr_addr", longint'(bus.ub_wr_addr_o), 0);
    check_val("reset ub_wr_data", longint'(bus.ub_wr_data_o), 0);
    check_val("reset acc_ready", longint'(bus.acc_ready_o), 0);
    check_val("reset busy", longint'(busy_o), 0);
    check_val("reset done", longint'(done_o), 0);
    check_val("reset sat", longint'(sat_o), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    lanes_q = '{5, -3, 127, 0};
    run_job("basic", 1'b0, 0, 'h10, 1, 0, 1'b0);
    lanes_q = '{-100, 24, 23, 5000};
    run_job("relu_round_sat", 1'b1, 4, 'h20, 1, 1, 1'b0);
    lanes_q = '{-300, -3, 3, -256};
    run_job("neg_sat", 1'b0, 1, 'h40, 1, 2, 1'b0);
    lanes_q = '{10, -20, 30, -40, 50, -60, 70, -80};
    run_job("wrap", 1'b0, 2, 'hFE, 2, N + 3, 1'b0);
    lanes_q.delete();
    run_job("empty", 1'b0, 0, 'h33, 0, 0, 1'b0);
    lanes_q = '{-9, 100, 1000, -5000, 17, -17, 255, 256};
    run_job("ignored_start", 1'b1, 3, 'h90, 2, 0, 1'b1);

    // Reset in the middle of a drain: saturating lane 0 sets sat first.
    lanes_q = '{-1000, 50, 60, 70};
    wr_q.delete();
    done_q.delete();
    start_i = 1'b1; relu_en_i = 1'b0; shift_i = 5'd0;
    base_addr_i = 8'h80; row_count_i = 8'd1;
    @(negedge clk);
    start_i = 1'b0;
    present_row(build_row(0), ok, h);
    for (int t = 0; t < 50 && wr_q.size() < 2; t++) begin
      @(negedge clk);
      #1;
    end
    check_val("rst two writes seen", wr_q.size(), 2);
    check_val("rst sat before reset", longint'(sat_o), 1);
    reset_n = 1'b0;
    #1;
    check_val("rst ub_wr_en", longint'(bus.ub_wr_en_o), 0);
    check_val("rst ub_wr_addr", longint'(bus.ub_wr_addr_o), 0);
    check_val("rst ub_wr_data", longint'(bus.ub_wr_data_o), 0);
    check_val("rst busy", longint'(busy_o), 0);
    check_val("rst sat", longint'(sat_o), 0);
    check_val("rst done", longint'(done_o), 0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst no more writes", wr_q.size(), 2);
    check_val("rst no done", done_q.size(), 0);
    check_val("rst idle after release", longint'(busy_o), 0);
    @(negedge clk);
    lanes_q = '{1, 2, 3, 4};
    run_job("after_reset", 1'b0, 0, 'hC0, 1, 0, 1'b0);

    for (int j = 0; j < 10; j++) begin
      cnt = $urandom_range(1, 3);
      lanes_q.delete();
      for (int i = 0; i < cnt * N; i++) lanes_q.push_back(rand_lane());
      run_job("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 255),
              cnt, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
